// File: rtl/ysyx_22050019_mem_arbiter_if.sv
// Bus bundle between the IF/LS requesters, the memory arbiter and the data-memory port.
// Latency: none (wires only).
// Backpressure: valid/ready on both request legs; responses are unthrottled one-cycle pulses.
interface ysyx_22050019_mem_arbiter_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    // Instruction fetch requester (read-only)
    logic              if_req_valid;
    logic              if_req_ready;
    logic [AW-1:0]     if_addr;
    logic              if_rsp_valid;
    logic [DW-1:0]     if_rdata;

    // Load/store requester
    logic              ls_req_valid;
    logic              ls_req_ready;
    logic              ls_we;
    logic [AW-1:0]     ls_addr;
    logic [DW-1:0]     ls_wdata;
    logic [DW/8-1:0]   ls_wmask;
    logic              ls_rsp_valid;
    logic [DW-1:0]     ls_rdata;

    // Downstream memory port
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_wmask;
    logic              mem_rsp_valid;
    logic [DW-1:0]     mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req_valid, if_addr,
        output if_req_ready, if_rsp_valid, if_rdata,
        input  ls_req_valid, ls_we, ls_addr, ls_wdata, ls_wmask,
        output ls_req_ready, ls_rsp_valid, ls_rdata,
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    // Environment side: requesters plus the memory they reach through the arbiter
    modport master (
        output if_req_valid, if_addr,
        input  if_req_ready, if_rsp_valid, if_rdata,
        output ls_req_valid, ls_we, ls_addr, ls_wdata, ls_wmask,
        input  ls_req_ready, ls_rsp_valid, ls_rdata,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/ysyx_22050019_mem_arbiter.sv
// Shares one data-memory port between IF (read) and LS (read/write), one transaction in flight.
// Latency: accept edge -> REQ -> WAIT -> response edge, rsp_valid one cycle after mem_rsp_valid.
// Backpressure: requesters see ready=0 while busy; REQ holds mem_req_valid and fields until mem_req_ready.
module ysyx_22050019_mem_arbiter #(
    parameter int AW            = 64,
    parameter int DW            = 64,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ysyx_22050019_mem_arbiter_if.slave    bus,
    output logic                          busy,
    output logic                          owner_ls
);
    localparam int SW = $clog2(MAX_LS_STREAK + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state;
    logic [SW-1:0]     streak;
    logic              req_we;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_wdata;
    logic [DW/8-1:0]   req_wmask;
    logic              if_rsp_q;
    logic              ls_rsp_q;
    logic [DW-1:0]     if_rdata_q;
    logic [DW-1:0]     ls_rdata_q;

    logic              streak_full;
    logic              grant_ls;
    logic              grant_if;

    // LS wins by default; IF takes the port once it has watched MAX_LS_STREAK LS grants go by.
    always_comb begin
        streak_full = (streak == SW'(MAX_LS_STREAK));
        grant_ls    = (state == IDLE) && bus.ls_req_valid && !(bus.if_req_valid && streak_full);
        grant_if    = (state == IDLE) && bus.if_req_valid && !grant_ls;
    end

    assign bus.if_req_ready  = grant_if;
    assign bus.ls_req_ready  = grant_ls;
    assign bus.mem_req_valid = (state == REQ);
    assign bus.mem_we        = req_we;
    assign bus.mem_addr      = req_addr;
    assign bus.mem_wdata     = req_wdata;
    assign bus.mem_wmask     = req_wmask;
    assign bus.if_rsp_valid  = if_rsp_q;
    assign bus.if_rdata      = if_rdata_q;
    assign bus.ls_rsp_valid  = ls_rsp_q;
    assign bus.ls_rdata      = ls_rdata_q;
    assign busy              = (state != IDLE);

    // Transaction FSM: latch the winner, hold the downstream request, route the response back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            streak     <= '0;
            owner_ls   <= 1'b0;
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_wmask  <= '0;
            if_rsp_q   <= 1'b0;
            ls_rsp_q   <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            if_rsp_q <= 1'b0;
            ls_rsp_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ls) begin
                        req_we    <= bus.ls_we;
                        req_addr  <= bus.ls_addr;
                        req_wdata <= bus.ls_wdata;
                        req_wmask <= bus.ls_wmask;
                        owner_ls  <= 1'b1;
                        state     <= REQ;
                        // Only grants that make IF wait count towards its starvation cap.
                        if (bus.if_req_valid && !streak_full) begin
                            streak <= streak + SW'(1);
                        end
                    end else if (grant_if) begin
                        req_we    <= 1'b0;
                        req_addr  <= bus.if_addr;
                        req_wdata <= '0;
                        req_wmask <= '0;
                        owner_ls  <= 1'b0;
                        streak    <= '0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        if (owner_ls) begin
                            ls_rdata_q <= bus.mem_rdata;
                            ls_rsp_q   <= 1'b1;
                        end else begin
                            if_rdata_q <= bus.mem_rdata;
                            if_rsp_q   <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22050019_mem_arbiter.sv
// Self-checking bench for the IF/LS memory arbiter with a response-queue scoreboard.
// Latency: drives inputs 1 ns after the rising edge, samples outputs on the falling edge.
// Backpressure: memory model inserts programmable ready and response delays.
module tb_ysyx_22050019_mem_arbiter;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int MAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic owner_ls;

    always #5 clk = ~clk;

    ysyx_22050019_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ysyx_22050019_mem_arbiter #(.AW(AW), .DW(DW), .MAX_LS_STREAK(MAX)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .owner_ls (owner_ls)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] if_exp_q[$];
    logic [DW-1:0] ls_exp_q[$];

    // Memory model controls; manual drive is used while the model is disabled.
    bit          model_en    = 1'b0;
    int          ready_delay = 0;
    int          rsp_delay   = 1;
    logic        man_ready   = 1'b0;
    logic        man_rsp     = 1'b0;
    logic [DW-1:0] man_rdata = '0;
    logic        mdl_ready   = 1'b0;
    logic        mdl_rsp     = 1'b0;
    logic [DW-1:0] mdl_rdata = '0;

    assign bus.mem_req_ready = model_en ? mdl_ready : man_ready;
    assign bus.mem_rsp_valid = model_en ? mdl_rsp   : man_rsp;
    assign bus.mem_rdata     = model_en ? mdl_rdata : man_rdata;

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 64'h8000_0000) return 64'h0000_0413;
        return {~a[31:0], a[31:0]};
    endfunction

    // Memory model: accepts after ready_delay cycles, responds rsp_delay+1 cycles after the handshake.
    initial begin : mem_model
        int mst;
        int cnt;
        logic [AW-1:0] cap;
        mst = 0;
        cnt = 0;
        cap = '0;
        forever begin
            @(posedge clk);
            #1;
            mdl_ready = 1'b0;
            mdl_rsp   = 1'b0;
            if (!model_en) begin
                mst = 0;
                cnt = 0;
            end else if (mst == 0) begin
                if (bus.mem_req_valid === 1'b1) begin
                    if (cnt >= ready_delay) begin
                        mdl_ready = 1'b1;
                        cap = bus.mem_addr;
                        cnt = 0;
                        mst = 1;
                    end else begin
                        cnt++;
                    end
                end
            end else begin
                if (cnt >= rsp_delay) begin
                    mdl_rsp   = 1'b1;
                    mdl_rdata = mem_fn(cap);
                    cnt = 0;
                    mst = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    task automatic test_reset();
        logic [7:0] ctl;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        ctl = {busy, owner_ls, bus.if_req_ready, bus.ls_req_ready,
               bus.if_rsp_valid, bus.ls_rsp_valid, bus.mem_req_valid, bus.mem_we};
        checks++;
        if (ctl !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctl got %b want 00000000", ctl);
        end
        checks++;
        if ({bus.if_rdata, bus.ls_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !== '0) begin
            errors++;
            $display("FAIL reset_data if_rdata %h ls_rdata %h mem_addr %h mem_wdata %h mem_wmask %h want all 0",
                     bus.if_rdata, bus.ls_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_wmask);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy got %b want 0", busy);
        end
    endtask

    task automatic test_single_if();
        logic [AW-1:0] a;
        logic [DW-1:0] e;
        int lat;
        bit seen;
        bit ls_seen;
        a = 64'h8000_0000;
        model_en = 1'b1; ready_delay = 0; rsp_delay = 1;
        @(posedge clk); #1;
        bus.if_req_valid = 1'b1;
        bus.if_addr = a;
        if_exp_q.push_back(mem_fn(a));
        @(negedge clk);
        checks++;
        if ({bus.if_req_ready, bus.ls_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL if_grant ready{if,ls} got %b want 10", {bus.if_req_ready, bus.ls_req_ready});
        end
        @(posedge clk); #1;
        bus.if_req_valid = 1'b0;
        bus.if_addr = '1;
        @(negedge clk);
        checks++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== a ||
            bus.mem_wmask !== '0 || bus.if_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL if_req valid %b we %b addr %h wmask %h ready %b want 1 0 %h 0 0",
                     bus.mem_req_valid, bus.mem_we, bus.mem_addr, bus.mem_wmask, bus.if_req_ready, a);
        end
        lat = 1; seen = 0; ls_seen = 0;
        while (!seen && lat < 20) begin
            if (bus.ls_rsp_valid === 1'b1) ls_seen = 1;
            if (bus.if_rsp_valid === 1'b1) seen = 1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        checks++;
        if (!seen || lat != 4) begin
            errors++;
            $display("FAIL if_latency seen %0d cycles %0d want seen 1 cycles 4", seen, lat);
        end
        if (seen) begin
            checks++;
            if (if_exp_q.size() == 0) begin
                errors++;
                $display("FAIL if_rdata unexpected response %h", bus.if_rdata);
            end else begin
                e = if_exp_q.pop_front();
                if (bus.if_rdata !== e) begin
                    errors++;
                    $display("FAIL if_rdata got %h want %h", bus.if_rdata, e);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (bus.if_rsp_valid !== 1'b0 || bus.if_rdata !== 64'h413 || ls_seen || bus.ls_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL if_pulse_hold rsp %b rdata %h ls_seen %0d want 0 413 0",
                     bus.if_rsp_valid, bus.if_rdata, ls_seen);
        end
    endtask

    task automatic test_ls_write_bp();
        logic [AW-1:0] a;
        logic [DW-1:0] e;
        int held;
        int bad;
        int n;
        bit seen;
        bit if_seen;
        a = 64'h8000_1000;
        ready_delay = 3;
        @(posedge clk); #1;
        bus.ls_req_valid = 1'b1;
        bus.ls_we = 1'b1;
        bus.ls_addr = a;
        bus.ls_wdata = 64'hDEAD_BEEF;
        bus.ls_wmask = 8'h0F;
        ls_exp_q.push_back(mem_fn(a));
        @(negedge clk);
        checks++;
        if ({bus.if_req_ready, bus.ls_req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL ls_grant ready{if,ls} got %b want 01", {bus.if_req_ready, bus.ls_req_ready});
        end
        @(posedge clk); #1;
        bus.ls_req_valid = 1'b0;
        bus.ls_we = 1'b0;
        bus.ls_addr = '1;
        bus.ls_wdata = '0;
        bus.ls_wmask = '1;
        @(negedge clk);
        held = 0; bad = 0;
        while (bus.mem_req_valid === 1'b1 && held < 20) begin
            held++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== a || bus.mem_wdata !== 64'hDEAD_BEEF ||
                bus.mem_wmask !== 8'h0F) bad++;
            @(negedge clk);
        end
        checks++;
        if (held != 4) begin
            errors++;
            $display("FAIL ls_bp_hold cycles got %0d want 4", held);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ls_bp_fields unstable cycles got %0d want 0", bad);
        end
        n = 0; seen = 0; if_seen = 0;
        while (!seen && n < 20) begin
            if (bus.if_rsp_valid === 1'b1) if_seen = 1;
            if (bus.ls_rsp_valid === 1'b1) seen = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        checks++;
        if (!seen || if_seen) begin
            errors++;
            $display("FAIL ls_rsp seen %0d if_seen %0d want 1 0", seen, if_seen);
        end
        if (seen) begin
            checks++;
            if (ls_exp_q.size() == 0) begin
                errors++;
                $display("FAIL ls_rdata unexpected response %h", bus.ls_rdata);
            end else begin
                e = ls_exp_q.pop_front();
                if (bus.ls_rdata !== e) begin
                    errors++;
                    $display("FAIL ls_rdata got %h want %h", bus.ls_rdata, e);
                end
            end
        end
        ready_delay = 0;
        @(negedge clk);
    endtask

    // Holds both requesters valid until each has completed its quota; records the grant order.
    task automatic run_both(input int n_ls, input int n_if, output string order);
        int li;
        int ii;
        int lr;
        int ir;
        int guard;
        bit gl;
        bit gi;
        bit both_rdy;
        logic [AW-1:0] la;
        logic [AW-1:0] ia;
        logic [DW-1:0] e;
        li = 0; ii = 0; lr = 0; ir = 0; guard = 0; both_rdy = 0;
        order = "";
        model_en = 1'b1;
        @(posedge clk); #1;
        if (n_ls > 0) begin
            la = 64'h8000_2000;
            bus.ls_req_valid = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = la;
            bus.ls_wdata = '0; bus.ls_wmask = '0;
            ls_exp_q.push_back(mem_fn(la));
        end
        if (n_if > 0) begin
            ia = 64'h8000_0100;
            bus.if_req_valid = 1'b1; bus.if_addr = ia;
            if_exp_q.push_back(mem_fn(ia));
        end
        while ((lr < n_ls || ir < n_if) && guard < 400) begin
            @(negedge clk);
            guard++;
            gl = (bus.ls_req_ready === 1'b1);
            gi = (bus.if_req_ready === 1'b1);
            if (gl && gi) both_rdy = 1;
            if (gl) order = {order, "L"};
            if (gi) order = {order, "I"};
            if (bus.ls_rsp_valid === 1'b1) begin
                lr++;
                checks++;
                if (ls_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL arb_ls_rdata unexpected response %h", bus.ls_rdata);
                end else begin
                    e = ls_exp_q.pop_front();
                    if (bus.ls_rdata !== e) begin
                        errors++;
                        $display("FAIL arb_ls_rdata got %h want %h", bus.ls_rdata, e);
                    end
                end
            end
            if (bus.if_rsp_valid === 1'b1) begin
                ir++;
                checks++;
                if (if_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL arb_if_rdata unexpected response %h", bus.if_rdata);
                end else begin
                    e = if_exp_q.pop_front();
                    if (bus.if_rdata !== e) begin
                        errors++;
                        $display("FAIL arb_if_rdata got %h want %h", bus.if_rdata, e);
                    end
                end
            end
            @(posedge clk); #1;
            if (gl) begin
                li++;
                if (li < n_ls) begin
                    la = 64'h8000_2000 + AW'(8 * li);
                    bus.ls_addr = la;
                    ls_exp_q.push_back(mem_fn(la));
                end else begin
                    bus.ls_req_valid = 1'b0;
                end
            end
            if (gi) begin
                ii++;
                if (ii < n_if) begin
                    ia = 64'h8000_0100 + AW'(4 * ii);
                    bus.if_addr = ia;
                    if_exp_q.push_back(mem_fn(ia));
                end else begin
                    bus.if_req_valid = 1'b0;
                end
            end
        end
        checks++;
        if (lr != n_ls || ir != n_if) begin
            errors++;
            $display("FAIL arb_done ls %0d if %0d want %0d %0d", lr, ir, n_ls, n_if);
        end
        checks++;
        if (both_rdy) begin
            errors++;
            $display("FAIL arb_exclusive both readies high got 1 want 0");
        end
    endtask

    task automatic test_simultaneous();
        string ord;
        run_both(1, 1, ord);
        checks++;
        if (ord != "LI") begin
            errors++;
            $display("FAIL simultaneous order got %s want LI", ord);
        end
    endtask

    task automatic test_starvation();
        string ord;
        run_both(9, 2, ord);
        checks++;
        if (ord != "LLLLILLLLIL") begin
            errors++;
            $display("FAIL starvation order got %s want LLLLILLLLIL", ord);
        end
    endtask

    task automatic test_spurious();
        logic [AW-1:0] a;
        logic [DW-1:0] e;
        int n;
        bit seen;
        a = 64'h8000_0200;
        model_en = 1'b0;
        @(posedge clk); #1;
        man_rsp = 1'b1; man_rdata = 64'hBAD0_BAD0;
        @(posedge clk); #1;
        man_rsp = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.if_rsp_valid !== 1'b0 || bus.ls_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL spurious_idle busy %b if_rsp %b ls_rsp %b want 0 0 0",
                     busy, bus.if_rsp_valid, bus.ls_rsp_valid);
        end
        @(posedge clk); #1;
        bus.if_req_valid = 1'b1; bus.if_addr = a;
        if_exp_q.push_back(mem_fn(a));
        @(posedge clk); #1;
        bus.if_req_valid = 1'b0;
        man_rsp = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        man_rsp = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || bus.mem_req_valid !== 1'b1 || bus.if_rsp_valid !== 1'b0 ||
            bus.ls_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL spurious_req busy %b mem_req_valid %b if_rsp %b ls_rsp %b want 1 1 0 0",
                     busy, bus.mem_req_valid, bus.if_rsp_valid, bus.ls_rsp_valid);
        end
        model_en = 1'b1;
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.if_rsp_valid === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || if_exp_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_resume seen %0d queued %0d want 1 1", seen, if_exp_q.size());
        end else begin
            e = if_exp_q.pop_front();
            if (bus.if_rdata !== e) begin
                errors++;
                $display("FAIL spurious_resume rdata got %h want %h", bus.if_rdata, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        bit pulse;
        bit was_busy;
        model_en = 1'b0;
        @(posedge clk); #1;
        bus.ls_req_valid = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 64'h8000_0010;
        bus.ls_wdata = '0; bus.ls_wmask = '0;
        @(posedge clk); #1;
        bus.ls_req_valid = 1'b0;
        man_ready = 1'b1;
        @(posedge clk); #1;
        man_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || bus.mem_req_valid !== 1'b0 || owner_ls !== 1'b1) begin
            errors++;
            $display("FAIL midwait_state busy %b mem_req_valid %b owner_ls %b want 1 0 1",
                     busy, bus.mem_req_valid, owner_ls);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, owner_ls, bus.mem_req_valid, bus.if_rsp_valid, bus.ls_rsp_valid} !== 5'b0 ||
            bus.mem_addr !== '0) begin
            errors++;
            $display("FAIL midwait_async busy %b owner %b mem_req_valid %b mem_addr %h want 0 0 0 0",
                     busy, owner_ls, bus.mem_req_valid, bus.mem_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        man_rsp = 1'b1; man_rdata = 64'h1234_5678;
        @(posedge clk); #1;
        man_rsp = 1'b0;
        pulse = 0; was_busy = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.if_rsp_valid !== 1'b0 || bus.ls_rsp_valid !== 1'b0) pulse = 1;
            if (busy !== 1'b0) was_busy = 1;
        end
        checks++;
        if (pulse || was_busy) begin
            errors++;
            $display("FAIL midwait_rsp pulse %0d busy %0d want 0 0", pulse, was_busy);
        end
        checks++;
        if ({bus.if_rdata, bus.ls_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.mem_we, owner_ls} !== '0) begin
            errors++;
            $display("FAIL midwait_outputs if_rdata %h ls_rdata %h mem_addr %h owner %b want all 0",
                     bus.if_rdata, bus.ls_rdata, bus.mem_addr, owner_ls);
        end
    endtask

    initial begin
        bus.if_req_valid = 1'b0;
        bus.if_addr      = '0;
        bus.ls_req_valid = 1'b0;
        bus.ls_we        = 1'b0;
        bus.ls_addr      = '0;
        bus.ls_wdata     = '0;
        bus.ls_wmask     = '0;
        test_reset();
        test_single_if();
        test_ls_write_bp();
        test_simultaneous();
        test_starvation();
        test_spurious();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
